// File: rtl/debounce_edge.sv
// debounce_edge: qualifies a raw single-bit input into a clean registered
// level and emits a one-cycle strobe on every accepted transition.
//
// A new level is accepted only after STABLE_CYCLES consecutive identical
// samples of the sample register `s`. Any sample that bounces back restarts
// qualification from scratch.
//
// Optional build macro DEBOUNCE_SYNC_EN: when defined, a two-flop
// synchronizer (sync0, sync1) precedes `s`, for use when `din` is a raw pin.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   din        in   raw input
//   level      out  debounced level (registered)
//   rise       out  one-cycle pulse when level goes 0->1
//   fall       out  one-cycle pulse when level goes 1->0
//   ena_pulse  out  rise | fall, registered; enable for the downstream flop
//   busy       out  high while a candidate transition is being qualified
module debounce_edge #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic ena_pulse,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject illegal qualification lengths at elaboration.
    if (STABLE_CYCLES < 2) begin : g_param_check
        $error("debounce_edge: STABLE_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_q, s_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             ena_q, ena_d;
    logic             busy_q, busy_d;

`ifdef DEBOUNCE_SYNC_EN
    logic             sync0_q, sync0_d;
    logic             sync1_q, sync1_d;
`endif

    // Next-state and output logic; the FSM looks only at the sample register.
    always_comb begin
`ifdef DEBOUNCE_SYNC_EN
        sync0_d = din;
        sync1_d = sync0_q;
        s_d     = sync1_q;
`else
        s_d     = din;
`endif
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        case (state_q)
            STABLE_LO: begin
                if (s_q) begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND_HI: begin
                if (!s_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s_q) begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND_LO: begin
                if (s_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase

        ena_d  = rise_d | fall_d;
        // busy reflects the state being entered so it lines up with the FSM.
        busy_d = (state_d == PEND_HI) || (state_d == PEND_LO);
    end

    // State and output registers; reset discards any pending candidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            s_q     <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            ena_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DEBOUNCE_SYNC_EN
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            ena_q   <= ena_d;
            busy_q  <= busy_d;
`ifdef DEBOUNCE_SYNC_EN
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
`endif
        end
    end

    assign level     = level_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign ena_pulse = ena_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: directed bench for debounce_edge with a run-length
// reference model checked every cycle plus literal timing expectations.
module tb_debounce_edge;

    localparam int unsigned S = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int unsigned DLY = 3;
`else
    localparam int unsigned DLY = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic level;
    logic rise;
    logic fall;
    logic ena_pulse;
    logic busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_edge #(.STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .ena_pulse (ena_pulse),
        .busy      (busy)
    );

    task automatic cmp(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: the input seen by the qualifier is din delayed by DLY
    // edges (zero after reset); a level flips once S consecutive samples
    // differ from it, and any agreeing sample resets the run.
    logic [2:0] m_pipe  = '0;
    logic       m_in;
    logic       m_level = 1'b0;
    logic       m_rise  = 1'b0;
    logic       m_fall  = 1'b0;
    int         m_run   = 0;
    logic       m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pipe  = '0;
            m_level = 1'b0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_run   = 0;
            m_valid = 1'b1;
        end else begin
            m_in   = m_pipe[DLY-1];
            m_pipe = {m_pipe[1:0], din};
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_in != m_level) begin
                m_run++;
                if (m_run == int'(S)) begin
                    m_level = m_in;
                    m_rise  = m_in;
                    m_fall  = !m_in;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    // Per-cycle comparison against the model, plus activity counters.
    int pulse_cnt = 0;
    int busy_cnt  = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("model_level", level, m_level);
            cmp("model_rise", rise, m_rise);
            cmp("model_fall", fall, m_fall);
            cmp("model_ena_pulse", ena_pulse, m_rise | m_fall);
            cmp("model_busy", busy, m_run != 0);
            cmp("rise_fall_excl", rise & fall, 1'b0);
        end
        if (rise | fall | ena_pulse) pulse_cnt++;
        if (busy) busy_cnt++;
    end

    int p0;
    int b0;
    int runs [10] = '{1, 2, 3, 4, 5, 1, 6, 3, 4, 8};

    initial begin
        rst = 1'b1;
        din = 1'b1;

        // Reset held two cycles with din high.
        repeat (2) @(negedge clk);
        cmp("rst_level", level, 1'b0);
        cmp("rst_rise", rise, 1'b0);
        cmp("rst_fall", fall, 1'b0);
        cmp("rst_ena", ena_pulse, 1'b0);
        cmp("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // Release with din high: rise only after full qualification.
        repeat (DLY + S - 1) @(negedge clk);
        cmp("s1_level_early", level, 1'b0);
        @(negedge clk);
        cmp("s1_level", level, 1'b1);
        cmp("s1_rise", rise, 1'b1);
        cmp("s1_ena", ena_pulse, 1'b1);
        @(negedge clk);
        cmp("s1_rise_drop", rise, 1'b0);
        cmp("s1_level_hold", level, 1'b1);

        // Clean fall from stable high.
        din = 1'b0;
        repeat (DLY + S - 1) @(negedge clk);
        cmp("s4_level_early", level, 1'b1);
        @(negedge clk);
        cmp("s4_level", level, 1'b0);
        cmp("s4_fall", fall, 1'b1);
        cmp("s4_ena", ena_pulse, 1'b1);
        cmp("s4_rise", rise, 1'b0);
        @(negedge clk);
        cmp("s4_fall_drop", fall, 1'b0);
        repeat (3) @(negedge clk);

        // Clean rise from stable low.
        din = 1'b1;
        repeat (DLY) @(negedge clk);
        cmp("s2_busy_early", busy, 1'b0);
        @(negedge clk);
        cmp("s2_busy", busy, 1'b1);
        repeat (S - 2) @(negedge clk);
        cmp("s2_level_early", level, 1'b0);
        @(negedge clk);
        cmp("s2_level", level, 1'b1);
        cmp("s2_rise", rise, 1'b1);
        cmp("s2_ena", ena_pulse, 1'b1);
        @(negedge clk);
        cmp("s2_rise_drop", rise, 1'b0);
        din = 1'b0;
        repeat (DLY + S + 2) @(negedge clk);
        cmp("s2_back_low", level, 1'b0);

        // Three-cycle glitch is rejected.
        p0  = pulse_cnt;
        b0  = busy_cnt;
        din = 1'b1;
        repeat (3) @(negedge clk);
        din = 1'b0;
        repeat (DLY + S + 4) @(negedge clk);
        cmp("s3_level", level, 1'b0);
        cmp("s3_busy_end", busy, 1'b0);
        cmp_int("s3_pulses", pulse_cnt - p0, 0);
        cmp_int("s3_busy_cycles", busy_cnt - b0, 3);

        // Reset in the middle of a qualification (cnt=2).
        din = 1'b1;
        repeat (DLY + 2) @(negedge clk);
        cmp("s5_busy_pre", busy, 1'b1);
        p0  = pulse_cnt;
        rst = 1'b1;
        @(negedge clk);
        cmp("s5_busy_rst", busy, 1'b0);
        cmp("s5_level_rst", level, 1'b0);
        rst = 1'b0;
        repeat (DLY + S - 1) @(negedge clk);
        cmp("s5_level_early", level, 1'b0);
        cmp_int("s5_no_pulse", pulse_cnt - p0, 0);
        @(negedge clk);
        cmp("s5_level", level, 1'b1);
        cmp("s5_rise", rise, 1'b1);

        // Mixed run lengths, checked by the model each cycle.
        foreach (runs[i]) begin
            din = ~din;
            repeat (runs[i]) @(negedge clk);
        end
        din = 1'b0;
        repeat (DLY + S + 4) @(negedge clk);
        cmp("tail_level", level, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
